// File: rtl/pe_feeder_pkg.sv
// PE feeder shared types: default conf, feeder config and FSM states.
// Imported by the feeder top and its stream channels.
package PECfg;

  localparam int CFG_AW = 10;
  localparam int CW = 16;

  typedef struct packed {
    logic [7:0] dw;
    logic [7:0] aw;
  } conf_t;

  localparam conf_t Conf = '{dw: 8'd16, aw: 8'(CFG_AW)};

  typedef struct packed {
    logic [3:0]        pch;
    logic [3:0]        r;
    logic [3:0]        pm;
    logic [5:0]        tw;
    logic [3:0]        u;
    logic              pix_reuse;
    logic [CFG_AW-1:0] in_base;
    logic [CFG_AW-1:0] wt_base;
  } feed_cfg_t;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/pe_feeder_if.sv
// One feeder stream: buffer-memory read port plus rdy/ack PE handshake.
// master = feeder side, slave = memory/PE side.
interface pe_feeder_if #(
  parameter int DW = 16,
  parameter int AW = 10
);

  logic          mreq;
  logic [AW-1:0] maddr;
  logic [DW-1:0] mdat;
  logic          rdy;
  logic          ack;
  logic [DW-1:0] dat;

  modport master (
    output mreq, maddr, rdy, dat,
    input  mdat, ack
  );

  modport slave (
    input  mreq, maddr, rdy, dat,
    output mdat, ack
  );

endinterface

// File: rtl/pe_feed_chan.sv
// One stream: linear address counter, read-in-flight tracking and a
// 2-entry skid buffer with bypass of the word arriving from memory.
module pe_feed_chan
  import PECfg::*;
#(
  parameter int DW = 16,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          go,
  input  logic          run,
  input  logic [CW-1:0] n,
  input  logic [AW-1:0] base,
  pe_feeder_if.master   s,
  output logic          fin
);

  logic [DW-1:0] skid_q [2];
  logic          wp, rp, infl;
  logic [1:0]    occ, lvl;
  logic [CW-1:0] req_cnt, tx_cnt;
  logic [AW-1:0] addr;
  logic          pop, pull, push, room;

  // lvl counts the read in flight so the buffer can never overflow
  assign lvl  = occ + {1'b0, infl};
  assign pop  = s.rdy && s.ack;
  assign pull = pop && (occ != 2'd0);
  assign push = infl && !(pop && occ == 2'd0);
  assign room = (lvl < 2'd2) || (pop && lvl == 2'd2);

  assign s.rdy   = (occ != 2'd0) || infl;
  assign s.dat   = (occ != 2'd0) ? skid_q[rp] :
                   (infl ? s.mdat : '0);
  assign s.mreq  = run && (req_cnt != n) && room;
  assign s.maddr = addr;
  assign fin     = (tx_cnt + CW'(pop)) == n;

  always_ff @(posedge clk) begin
    if (rst) begin
      wp      <= 1'b0;
      rp      <= 1'b0;
      infl    <= 1'b0;
      occ     <= 2'd0;
      req_cnt <= '0;
      tx_cnt  <= '0;
      addr    <= '0;
    end else if (go) begin
      wp      <= 1'b0;
      rp      <= 1'b0;
      infl    <= 1'b0;
      occ     <= 2'd0;
      req_cnt <= '0;
      tx_cnt  <= '0;
      addr    <= base;
    end else begin
      infl <= s.mreq;
      occ  <= occ + {1'b0, push} - {1'b0, pull};
      if (s.mreq) begin
        req_cnt <= req_cnt + CW'(1);
        addr    <= addr + AW'(1);
      end
      if (push) wp <= ~wp;
      if (pull) rp <= ~rp;
      if (pop) tx_cnt <= tx_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) skid_q[wp] <= s.mdat;
  end

endmodule

// File: rtl/pe_feeder.sv
// PE feeder top: latches config on start, sizes both streams and runs
// the IDLE/RUN/DONE sequencer over two independent channels.
module pe_feeder
  import PECfg::*;
#(
  parameter int DW = 16,
  parameter int AW = CFG_AW
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  feed_cfg_t     i_cfg,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_in_mreq,
  output logic [AW-1:0] o_in_maddr,
  input  logic [DW-1:0] i_in_mdat,
  output logic          o_wt_mreq,
  output logic [AW-1:0] o_wt_maddr,
  input  logic [DW-1:0] i_wt_mdat,
  output logic          Input_rdy,
  input  logic          Input_ack,
  output logic [DW-1:0] Input_dat,
  output logic          Weight_rdy,
  input  logic          Weight_ack,
  output logic [DW-1:0] Weight_dat
);

  state_t        state;
  logic [CW-1:0] roww_c, nin_c, nwt_c;
  logic [CW-1:0] nin_q, nwt_q;
  logic          go, run, fin_in, fin_wt;

  pe_feeder_if #(.DW(DW), .AW(AW)) in_s ();
  pe_feeder_if #(.DW(DW), .AW(AW)) wt_s ();

  // a zero Tw or R empties the row regardless of the reuse formula
  always_comb begin
    roww_c = '0;
    if (i_cfg.tw != '0 && i_cfg.r != '0) begin
      if (i_cfg.pix_reuse)
        roww_c = CW'(i_cfg.tw) * CW'(i_cfg.u)
               + CW'(i_cfg.r) - CW'(1);
      else
        roww_c = CW'(i_cfg.tw) * CW'(i_cfg.r);
    end
    nin_c = CW'(i_cfg.pch) * roww_c;
    nwt_c = CW'(i_cfg.pch) * CW'(i_cfg.r)
          * CW'(i_cfg.pm);
  end

  assign go     = i_start && (state == ST_IDLE);
  assign run    = (state == ST_RUN);
  assign o_busy = run;
  assign o_done = (state == ST_DONE);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= ST_IDLE;
      nin_q <= '0;
      nwt_q <= '0;
    end else begin
      case (state)
        ST_IDLE: if (i_start) begin
          nin_q <= nin_c;
          nwt_q <= nwt_c;
          state <= (nin_c == '0 && nwt_c == '0) ?
                   ST_DONE : ST_RUN;
        end
        ST_RUN:  if (fin_in && fin_wt) state <= ST_DONE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign in_s.mdat  = i_in_mdat;
  assign in_s.ack   = Input_ack;
  assign o_in_mreq  = in_s.mreq;
  assign o_in_maddr = in_s.maddr;
  assign Input_rdy  = in_s.rdy;
  assign Input_dat  = in_s.dat;

  assign wt_s.mdat  = i_wt_mdat;
  assign wt_s.ack   = Weight_ack;
  assign o_wt_mreq  = wt_s.mreq;
  assign o_wt_maddr = wt_s.maddr;
  assign Weight_rdy = wt_s.rdy;
  assign Weight_dat = wt_s.dat;

  pe_feed_chan #(.DW(DW), .AW(AW)) u_in (
    .clk  (i_clk),
    .rst  (i_rst),
    .go   (go),
    .run  (run),
    .n    (nin_q),
    .base (AW'(i_cfg.in_base)),
    .s    (in_s),
    .fin  (fin_in)
  );

  pe_feed_chan #(.DW(DW), .AW(AW)) u_wt (
    .clk  (i_clk),
    .rst  (i_rst),
    .go   (go),
    .run  (run),
    .n    (nwt_q),
    .base (AW'(i_cfg.wt_base)),
    .s    (wt_s),
    .fin  (fin_wt)
  );

endmodule

// File: tb/tb_pe_feeder.sv
// Bench for pe_feeder: random buffer contents and acks, checked
// against stream word lists derived from the config arithmetic.
module tb_pe_feeder;
  import PECfg::*;

  localparam int DW = 16;
  localparam int AW = 10;
  localparam int MW = 1 << AW;

  logic          clk = 1'b0;
  logic          rst, start;
  feed_cfg_t     cfg;
  logic          busy, done;
  logic          wt_mreq, wt_rdy, wt_ack;
  logic [AW-1:0] wt_maddr;
  logic [DW-1:0] wt_mdat, wt_dat;

  pe_feeder_if #(.DW(DW), .AW(AW)) in_s ();

  pe_feeder #(.DW(DW), .AW(AW)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start),
    .i_cfg      (cfg),
    .o_busy     (busy),
    .o_done     (done),
    .o_in_mreq  (in_s.mreq),
    .o_in_maddr (in_s.maddr),
    .i_in_mdat  (in_s.mdat),
    .o_wt_mreq  (wt_mreq),
    .o_wt_maddr (wt_maddr),
    .i_wt_mdat  (wt_mdat),
    .Input_rdy  (in_s.rdy),
    .Input_ack  (in_s.ack),
    .Input_dat  (in_s.dat),
    .Weight_rdy (wt_rdy),
    .Weight_ack (wt_ack),
    .Weight_dat (wt_dat)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  int start_cyc;
  bit in_rnd, wt_rnd;

  logic [DW-1:0] in_mem [MW];
  logic [DW-1:0] wt_mem [MW];

  int got_in[$], got_wt[$], in_aq[$], wt_aq[$];
  int in_first, in_last, wt_first, wt_last;
  int in_rdy1, wt_rdy1, wt_rdy_n;
  int done_cnt, done_cyc, stab_err;
  bit p_in_st, p_wt_st;
  logic [DW-1:0] p_in_dat, p_wt_dat;

  always @(posedge clk) cyc <= cyc + 1;

  // synchronous-read buffer memories; junk when not requested
  always @(posedge clk) begin
    in_s.mdat <= in_s.mreq ? in_mem[in_s.maddr] : DW'($urandom);
    wt_mdat   <= wt_mreq ? wt_mem[wt_maddr] : DW'($urandom);
  end

  always @(posedge clk) begin
    #1;
    in_s.ack = in_rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    wt_ack   = wt_rnd ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) begin
    if (in_s.mreq === 1'b1) in_aq.push_back(int'(in_s.maddr));
    if (wt_mreq === 1'b1) wt_aq.push_back(int'(wt_maddr));
    if (in_s.rdy === 1'b1 && in_s.ack === 1'b1) begin
      got_in.push_back(int'(in_s.dat));
      if (in_first < 0) in_first = cyc;
      in_last = cyc;
    end
    if (wt_rdy === 1'b1 && wt_ack === 1'b1) begin
      got_wt.push_back(int'(wt_dat));
      if (wt_first < 0) wt_first = cyc;
      wt_last = cyc;
    end
    if (in_s.rdy === 1'b1 && in_rdy1 < 0) in_rdy1 = cyc;
    if (wt_rdy === 1'b1 && wt_rdy1 < 0) wt_rdy1 = cyc;
    if (wt_rdy === 1'b1) wt_rdy_n++;
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (rst === 1'b0) begin
      if (p_in_st && !(in_s.rdy === 1'b1 && in_s.dat === p_in_dat))
        stab_err++;
      if (p_wt_st && !(wt_rdy === 1'b1 && wt_dat === p_wt_dat))
        stab_err++;
    end
    p_in_st  = (in_s.rdy === 1'b1) && (in_s.ack !== 1'b1);
    p_wt_st  = (wt_rdy === 1'b1) && (wt_ack !== 1'b1);
    p_in_dat = in_s.dat;
    p_wt_dat = wt_dat;
  end

  function automatic feed_cfg_t mk(input int pch, input int r,
      input int pm, input int tw, input int u, input int pix,
      input int ib, input int wb);
    feed_cfg_t c;
    c.pch = 4'(pch);
    c.r = 4'(r);
    c.pm = 4'(pm);
    c.tw = 6'(tw);
    c.u = 4'(u);
    c.pix_reuse = 1'(pix);
    c.in_base = CFG_AW'(ib);
    c.wt_base = CFG_AW'(wb);
    return c;
  endfunction

  function automatic int f_roww(input feed_cfg_t c);
    if (c.tw == 0 || c.r == 0) return 0;
    if (c.pix_reuse) return int'(c.tw) * int'(c.u) + int'(c.r) - 1;
    return int'(c.tw) * int'(c.r);
  endfunction

  function automatic int f_nin(input feed_cfg_t c);
    return int'(c.pch) * f_roww(c);
  endfunction

  function automatic int f_nwt(input feed_cfg_t c);
    return int'(c.pch) * int'(c.r) * int'(c.pm);
  endfunction

  // 0: input data, 1: input addr, 2: weight data, 3: weight addr
  function automatic int seq_errs(input int which, input int base,
      input int n);
    int q[$];
    int e, want;
    e = 0;
    case (which)
      0: q = got_in;
      1: q = in_aq;
      2: q = got_wt;
      default: q = wt_aq;
    endcase
    if (q.size() != n) e++;
    for (int i = 0; i < q.size() && i < n; i++) begin
      int a;
      a = (base + i) % MW;
      case (which)
        0: want = int'(in_mem[a]);
        2: want = int'(wt_mem[a]);
        default: want = a;
      endcase
      if (q[i] != want) e++;
    end
    return e;
  endfunction

  task automatic clear_mon();
    got_in.delete();
    got_wt.delete();
    in_aq.delete();
    wt_aq.delete();
    in_first = -1; in_last = -1;
    wt_first = -1; wt_last = -1;
    in_rdy1 = -1; wt_rdy1 = -1;
    wt_rdy_n = 0; done_cnt = 0;
    done_cyc = -1; stab_err = 0;
  endtask

  task automatic run_job(input feed_cfg_t c, input bit ri,
      input bit rw);
    int k;
    clear_mon();
    in_rnd = ri;
    wt_rnd = rw;
    @(posedge clk); #1;
    cfg = c;
    start = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    while (done_cnt == 0 && k < 5000) begin
      @(negedge clk); #1;
      k++;
    end
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (done_cnt == 0)
      $display("FAIL job_timeout: done seen %0d want >0", done_cnt);
    else passed++;
    in_rnd = 1'b0;
    wt_rnd = 1'b0;
  endtask

  task automatic test_reset();
    clear_mon();
    rst = 1'b1;
    start = 1'b1;
    cfg = mk(2, 3, 2, 2, 1, 1, 0, 100);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, in_s.mreq, in_s.rdy, wt_mreq, wt_rdy,
         in_s.maddr, wt_maddr, in_s.dat, wt_dat} !== '0)
      $display("FAIL reset_outs: busy %b rdy %b/%b want all 0",
               busy, in_s.rdy, wt_rdy);
    else passed++;
    @(posedge clk); #1;
    rst = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || in_aq.size() != 0)
      $display("FAIL reset_start_ignored: busy %b mreqs %0d want 0",
               busy, in_aq.size());
    else passed++;
  endtask

  task automatic test_basic();
    feed_cfg_t c;
    int e;
    c = mk(2, 3, 2, 2, 1, 1, 0, 100);
    run_job(c, 1'b0, 1'b0);
    e = seq_errs(0, 0, f_nin(c)) + seq_errs(1, 0, f_nin(c));
    checks++;
    if (e != 0 || got_in.size() != 8)
      $display("FAIL basic_in: errs %0d words %0d want 0/8",
               e, got_in.size());
    else passed++;
    e = seq_errs(2, 100, f_nwt(c)) + seq_errs(3, 100, f_nwt(c));
    checks++;
    if (e != 0 || got_wt.size() != 12)
      $display("FAIL basic_wt: errs %0d words %0d want 0/12",
               e, got_wt.size());
    else passed++;
    checks++;
    if (in_rdy1 != start_cyc + 2 || wt_rdy1 != start_cyc + 2)
      $display("FAIL basic_first_rdy: %0d/%0d want %0d",
               in_rdy1 - start_cyc, wt_rdy1 - start_cyc, 2);
    else passed++;
    checks++;
    if (in_last - in_first != 7 || wt_last - wt_first != 11)
      $display("FAIL basic_rate: spans %0d/%0d want 7/11",
               in_last - in_first, wt_last - wt_first);
    else passed++;
    checks++;
    if (done_cnt != 1)
      $display("FAIL basic_done: pulses %0d want 1", done_cnt);
    else passed++;
  endtask

  task automatic test_noreuse();
    feed_cfg_t c;
    int e;
    c = mk(2, 3, 2, 2, 1, 0, 0, 100);
    run_job(c, 1'b0, 1'b0);
    e = seq_errs(0, 0, f_nin(c)) + seq_errs(1, 0, f_nin(c));
    checks++;
    if (e != 0 || got_in.size() != 12)
      $display("FAIL noreuse_in: errs %0d words %0d want 0/12",
               e, got_in.size());
    else passed++;
  endtask

  task automatic test_stall();
    feed_cfg_t c;
    int e;
    c = mk(2, 3, 2, 2, 1, 1, 0, 100);
    run_job(c, 1'b1, 1'b0);
    e = seq_errs(0, 0, f_nin(c)) + seq_errs(1, 0, f_nin(c));
    checks++;
    if (e != 0)
      $display("FAIL stall_in: errs %0d want 0", e);
    else passed++;
    checks++;
    if (stab_err != 0)
      $display("FAIL stall_hold: violations %0d want 0", stab_err);
    else passed++;
    e = seq_errs(2, 100, f_nwt(c));
    checks++;
    if (e != 0 || wt_last - wt_first != 11
        || wt_first != start_cyc + 2)
      $display("FAIL stall_wt: errs %0d span %0d want 0/11",
               e, wt_last - wt_first);
    else passed++;
  endtask

  task automatic test_wrap();
    feed_cfg_t c;
    int e;
    c = mk(2, 3, 1, 2, 1, 1, 1020, 1022);
    run_job(c, 1'b0, 1'b0);
    e = seq_errs(1, 1020, f_nin(c));
    checks++;
    if (e != 0 || in_aq.size() != 8 || in_aq[4] != 0)
      $display("FAIL wrap_addr: errs %0d word4 %0d want 0/0",
               e, (in_aq.size() > 4) ? in_aq[4] : -1);
    else passed++;
    e = seq_errs(0, 1020, f_nin(c)) + seq_errs(2, 1022, f_nwt(c));
    checks++;
    if (e != 0)
      $display("FAIL wrap_data: errs %0d want 0", e);
    else passed++;
  endtask

  task automatic test_zero();
    feed_cfg_t c;
    int e;
    c = mk(2, 3, 0, 2, 1, 1, 0, 100);
    run_job(c, 1'b0, 1'b0);
    checks++;
    if (wt_rdy_n != 0 || wt_aq.size() != 0)
      $display("FAIL zero_pm_wt: rdy cycles %0d mreqs %0d want 0",
               wt_rdy_n, wt_aq.size());
    else passed++;
    e = seq_errs(0, 0, f_nin(c));
    checks++;
    if (e != 0 || done_cnt != 1)
      $display("FAIL zero_pm_in: errs %0d done %0d want 0/1",
               e, done_cnt);
    else passed++;
    c = mk(0, 3, 2, 2, 1, 1, 0, 100);
    run_job(c, 1'b0, 1'b0);
    checks++;
    if (done_cyc != start_cyc + 1)
      $display("FAIL zero_all_done: cycle %0d want 1",
               done_cyc - start_cyc);
    else passed++;
    checks++;
    if (in_rdy1 != -1 || wt_rdy1 != -1
        || in_aq.size() + wt_aq.size() != 0)
      $display("FAIL zero_all_quiet: rdy %0d/%0d want -1",
               in_rdy1, wt_rdy1);
    else passed++;
  endtask

  task automatic test_rst_mid();
    feed_cfg_t c;
    int k, e;
    c = mk(4, 3, 2, 5, 2, 1, 10, 200);
    clear_mon();
    @(posedge clk); #1;
    cfg = c;
    start = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    while (got_in.size() < 3 && k < 50) begin
      @(negedge clk); #1;
      k++;
    end
    checks++;
    if (got_in.size() != 3 || in_s.mreq !== 1'b1)
      $display("FAIL rst_mid_setup: words %0d mreq %b want 3/1",
               got_in.size(), in_s.mreq);
    else passed++;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, done, in_s.mreq, in_s.rdy, wt_mreq, wt_rdy,
         in_s.maddr, wt_maddr, in_s.dat, wt_dat} !== '0)
      $display("FAIL rst_mid_outs: rdy %b dat %0h want 0",
               in_s.rdy, in_s.dat);
    else passed++;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (got_in.size() != 3 || busy !== 1'b0)
      $display("FAIL rst_mid_abandon: words %0d busy %b want 3/0",
               got_in.size(), busy);
    else passed++;
    run_job(c, 1'b0, 1'b0);
    e = seq_errs(0, 10, f_nin(c)) + seq_errs(1, 10, f_nin(c));
    checks++;
    if (e != 0)
      $display("FAIL rst_mid_replay: errs %0d want 0", e);
    else passed++;
  endtask

  task automatic test_random();
    feed_cfg_t c;
    int e;
    for (int it = 0; it < 4; it++) begin
      c = mk(int'($urandom_range(1, 3)), int'($urandom_range(1, 3)),
             int'($urandom_range(1, 3)), int'($urandom_range(1, 3)),
             int'($urandom_range(1, 3)), int'($urandom_range(0, 1)),
             int'($urandom_range(0, MW - 1)),
             int'($urandom_range(0, MW - 1)));
      run_job(c, 1'b1, 1'b1);
      e = seq_errs(0, int'(c.in_base), f_nin(c))
        + seq_errs(1, int'(c.in_base), f_nin(c));
      checks++;
      if (e != 0)
        $display("FAIL rand%0d_in: errs %0d want 0", it, e);
      else passed++;
      e = seq_errs(2, int'(c.wt_base), f_nwt(c))
        + seq_errs(3, int'(c.wt_base), f_nwt(c));
      checks++;
      if (e != 0)
        $display("FAIL rand%0d_wt: errs %0d want 0", it, e);
      else passed++;
      checks++;
      if (stab_err != 0 || done_cnt != 1)
        $display("FAIL rand%0d_ctl: hold %0d done %0d want 0/1",
                 it, stab_err, done_cnt);
      else passed++;
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    cfg = '0;
    in_rnd = 1'b0;
    wt_rnd = 1'b0;
    for (int i = 0; i < MW; i++) begin
      in_mem[i] = DW'($urandom);
      wt_mem[i] = DW'($urandom);
    end
    test_reset();
    test_basic();
    test_noreuse();
    test_stall();
    test_wrap();
    test_zero();
    test_rst_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
